// File: rtl/apb_req_master.sv
// Simple request/grant front end driving a single APB master port.
// One transfer in flight at a time; optional ACCESS-phase timeout forces an error response.
module apb_req_master #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam int unsigned CNT_W   = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TO_LAST = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      rvalid_q, rvalid_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      timeout_hit;

    // The counter reaches TIMEOUT_CYCLES on the edge that ends the last permitted wait cycle.
    assign timeout_hit = TO_EN && (state_q == ST_ACCESS) && !pready_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_i) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (pready_i || timeout_hit) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pure decode of the state register, so the APB strobes never see the slave inputs.
    always_comb begin
        gnt_o     = 1'b0;
        psel_o    = 1'b0;
        penable_o = 1'b0;
        case (state_q)
            ST_IDLE:   gnt_o = req_i;
            ST_SETUP:  psel_o = 1'b1;
            ST_ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;

        if (gnt_o) begin
            paddr_d  = addr_i;
            pwrite_d = we_i;
            pwdata_d = we_i ? wdata_i : '0;
        end

        if (state_q == ST_SETUP) begin
            cnt_d = '0;
        end

        if (state_q == ST_ACCESS) begin
            if (pready_i) begin
                rvalid_d = 1'b1;
                err_d    = pslverr_i;
                rdata_d  = pwrite_q ? '0 : prdata_i;
            end else begin
                if (TO_EN && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (timeout_hit) begin
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    rdata_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign paddr_o  = paddr_q;
    assign pwdata_o = pwdata_q;
    assign pwrite_o = pwrite_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule
